// File: rtl/qos_pkg.sv
// Shared QoS types, constants and the pairwise priority comparison used by the
// memory request arbiter.
package qos_pkg;

  localparam int QOS_CORE_W   = 4;
  localparam int QOS_LEVEL_W  = 3;
  localparam int QOS_WEIGHT_W = 4;
  localparam int QOS_WAIT_W   = 16;

  localparam logic QOS_SRC_INSTR = 1'b0;
  localparam logic QOS_SRC_DATA  = 1'b1;

  typedef struct packed {
    logic [QOS_CORE_W-1:0]   core_id;
    logic                    urgent;
    logic [QOS_LEVEL_W-1:0]  qos_level;
    logic [QOS_WEIGHT_W-1:0] weight;
    logic [QOS_WAIT_W-1:0]   max_latency_cycles;
  } qos_config_t;

  // Internal arbiter state, exported for checkers and bring-up.
  typedef struct packed {
    logic [QOS_CORE_W-1:0]              core_id;
    logic                               rr_last;
    logic [1:0][QOS_WAIT_W-1:0]         wait_q;
    logic [1:0][QOS_WEIGHT_W-1:0]       credit_q;
  } qos_dbg_t;

  // 1 when port A beats port B on starvation, urgency, level, then credit.
  function automatic logic qos_prio_cmp(
    input qos_config_t             cfg_a,
    input qos_config_t             cfg_b,
    input logic [QOS_WAIT_W-1:0]   wait_a,
    input logic [QOS_WAIT_W-1:0]   wait_b,
    input logic [QOS_WEIGHT_W-1:0] credit_a,
    input logic [QOS_WEIGHT_W-1:0] credit_b
  );
    logic starve_a;
    logic starve_b;
    starve_a = (cfg_a.max_latency_cycles != '0) && (wait_a >= cfg_a.max_latency_cycles);
    starve_b = (cfg_b.max_latency_cycles != '0) && (wait_b >= cfg_b.max_latency_cycles);
    if (starve_a != starve_b)              return starve_a;
    if (cfg_a.urgent != cfg_b.urgent)      return cfg_a.urgent;
    if (cfg_a.qos_level != cfg_b.qos_level) return cfg_a.qos_level > cfg_b.qos_level;
    return credit_a > credit_b;
  endfunction

endpackage

// File: rtl/qos_mem_req_arbiter_if.sv
// Request-side and memory-side channels of the QoS memory request arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid never waits for ready, and ready may depend combinationally on valid.
interface qos_mem_req_arbiter_if
  import qos_pkg::*;
#(
  parameter int PAYLOAD_W = 64
);
  logic                 instr_req_valid_i;
  logic                 instr_req_ready_o;
  logic [PAYLOAD_W-1:0] instr_req_payload_i;
  qos_config_t          instr_qos_config_i;

  logic                 data_req_valid_i;
  logic                 data_req_ready_o;
  logic [PAYLOAD_W-1:0] data_req_payload_i;
  qos_config_t          data_qos_config_i;

  logic                 mem_req_valid_o;
  logic                 mem_req_ready_i;
  logic [PAYLOAD_W-1:0] mem_req_payload_o;
  qos_config_t          mem_req_qos_o;
  logic                 mem_req_src_o;
  logic [1:0]           starve_o;

  modport slave (
    input  instr_req_valid_i, instr_req_payload_i, instr_qos_config_i,
    input  data_req_valid_i, data_req_payload_i, data_qos_config_i,
    input  mem_req_ready_i,
    output instr_req_ready_o, data_req_ready_o,
    output mem_req_valid_o, mem_req_payload_o, mem_req_qos_o, mem_req_src_o, starve_o
  );

  modport master (
    output instr_req_valid_i, instr_req_payload_i, instr_qos_config_i,
    output data_req_valid_i, data_req_payload_i, data_qos_config_i,
    output mem_req_ready_i,
    input  instr_req_ready_o, data_req_ready_o,
    input  mem_req_valid_o, mem_req_payload_o, mem_req_qos_o, mem_req_src_o, starve_o
  );
endinterface

// File: rtl/qos_req_slice.sv
// One-deep valid/ready register slice; accepts new data whenever empty or
// draining in the same cycle, otherwise holds its content stable.
module qos_req_slice #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end
endmodule

// File: rtl/qos_mem_req_arbiter.sv
// Two-port QoS arbiter merging instruction-fetch and data requests onto one
// registered memory request channel.
module qos_mem_req_arbiter
  import qos_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int CORE_ID   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  qos_enable_i,
  qos_mem_req_arbiter_if.slave  bus,
  output qos_dbg_t              dbg_o
);
  localparam int SLICE_W = 1 + $bits(qos_config_t) + PAYLOAD_W;

  logic                    load;
  logic                    grant;
  logic                    winner;
  logic                    prefer_instr;
  logic                    prefer_data;
  logic [1:0]              req_valid;
  logic [1:0]              accept;
  qos_config_t             cfg [2];
  logic [QOS_WAIT_W-1:0]   wait_q [2];
  logic [QOS_WAIT_W-1:0]   wait_d [2];
  logic [QOS_WEIGHT_W-1:0] credit_q [2];
  logic [QOS_WEIGHT_W-1:0] credit_d [2];
  logic [1:0]              starve_q;
  logic [1:0]              starve_d;
  logic                    rr_last_q;
  qos_config_t             win_cfg;
  logic [PAYLOAD_W-1:0]    win_payload;
  logic [SLICE_W-1:0]      slice_out;

  assign req_valid = {bus.data_req_valid_i, bus.instr_req_valid_i};
  assign cfg[0]    = bus.instr_qos_config_i;
  assign cfg[1]    = bus.data_qos_config_i;

  always_comb begin
    prefer_instr = qos_prio_cmp(cfg[0], cfg[1], wait_q[0], wait_q[1], credit_q[0], credit_q[1]);
    prefer_data  = qos_prio_cmp(cfg[1], cfg[0], wait_q[1], wait_q[0], credit_q[1], credit_q[0]);
    winner       = ~rr_last_q;
    if (!req_valid[1])                     winner = QOS_SRC_INSTR;
    else if (!req_valid[0])                winner = QOS_SRC_DATA;
    else if (qos_enable_i && prefer_instr) winner = QOS_SRC_INSTR;
    else if (qos_enable_i && prefer_data)  winner = QOS_SRC_DATA;
  end

  // Gating with rst_ni keeps ready low while reset holds the slice empty.
  assign grant     = rst_ni && load && (|req_valid);
  assign accept[0] = grant && (winner == QOS_SRC_INSTR);
  assign accept[1] = grant && (winner == QOS_SRC_DATA);

  assign bus.instr_req_ready_o = accept[0];
  assign bus.data_req_ready_o  = accept[1];

  assign win_cfg     = winner ? cfg[1] : cfg[0];
  assign win_payload = winner ? bus.data_req_payload_i : bus.instr_req_payload_i;

  // Both credits empty means a new weighting round: reload before charging the winner.
  always_comb begin
    credit_d[0] = credit_q[0];
    credit_d[1] = credit_q[1];
    if (!qos_enable_i) begin
      credit_d[0] = '0;
      credit_d[1] = '0;
    end else if (grant) begin
      if (credit_q[0] == '0 && credit_q[1] == '0) begin
        credit_d[0] = cfg[0].weight;
        credit_d[1] = cfg[1].weight;
      end
      if (credit_d[winner] != '0) credit_d[winner] = credit_d[winner] - QOS_WEIGHT_W'(1);
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wait_d[p] = wait_q[p];
      if (!qos_enable_i || !req_valid[p] || accept[p]) wait_d[p] = '0;
      else if (wait_q[p] != '1)                       wait_d[p] = wait_q[p] + QOS_WAIT_W'(1);
      starve_d[p] = qos_enable_i && (cfg[p].max_latency_cycles != '0) &&
                    (wait_d[p] >= cfg[p].max_latency_cycles);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q[0]   <= '0;
      wait_q[1]   <= '0;
      credit_q[0] <= '0;
      credit_q[1] <= '0;
      starve_q    <= '0;
      rr_last_q   <= QOS_SRC_DATA;
    end else begin
      wait_q[0]   <= wait_d[0];
      wait_q[1]   <= wait_d[1];
      credit_q[0] <= credit_d[0];
      credit_q[1] <= credit_d[1];
      starve_q    <= starve_d;
      if (grant) rr_last_q <= winner;
    end
  end

  qos_req_slice #(.W(SLICE_W)) u_slice (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (grant),
    .in_data_i   ({winner, win_cfg, win_payload}),
    .in_ready_o  (load),
    .out_valid_o (bus.mem_req_valid_o),
    .out_ready_i (bus.mem_req_ready_i),
    .out_data_o  (slice_out)
  );

  assign {bus.mem_req_src_o, bus.mem_req_qos_o, bus.mem_req_payload_o} = slice_out;
  assign bus.starve_o = starve_q;

  always_comb begin
    dbg_o             = '0;
    dbg_o.core_id     = QOS_CORE_W'(CORE_ID);
    dbg_o.rr_last     = rr_last_q;
    dbg_o.wait_q[0]   = wait_q[0];
    dbg_o.wait_q[1]   = wait_q[1];
    dbg_o.credit_q[0] = credit_q[0];
    dbg_o.credit_q[1] = credit_q[1];
  end
endmodule
